// File: rtl/gate_vector_checker.sv
// Self-running stimulus/check engine for a combinational gate: walks every input vector,
// compares the settled output to EXPECT_TT. Optional capture via GATE_VECTOR_CHECKER_FIRST_FAIL_EN.
module gate_vector_checker #(
  parameter int                      N_IN          = 2,
  parameter int                      SETTLE_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0]    EXPECT_TT     = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] cur_vec
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
  ,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_y
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("gate_vector_checker: SETTLE_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [N_IN-1:0]   cur_vec_q, cur_vec_d;
  logic [N_IN:0]     err_q, err_d, err_next;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              mismatch;
  logic              ffv_q, ffv_d;
  logic [N_IN-1:0]   ffvec_q, ffvec_d;
  logic              ffy_q, ffy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dut_in_d  = dut_in_q;
    cur_vec_d = cur_vec_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    ffv_d     = ffv_q;
    ffvec_d   = ffvec_q;
    ffy_d     = ffy_q;
    // Case inequality so an X/Z output counts as a failure in simulation.
    mismatch  = (dut_y !== EXPECT_TT[cur_vec_q]);
    err_next  = (mismatch && (err_q != '1)) ? err_q + 1'b1 : err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_DRIVE;
          cur_vec_d = '0;
          err_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          ffv_d     = 1'b0;
          ffvec_d   = '0;
          ffy_d     = 1'b0;
        end
      end
      S_DRIVE: begin
        dut_in_d = cur_vec_q;
        cnt_d    = CNT_W'(SETTLE_CYCLES);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        err_d = err_next;
        if (mismatch && !ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = cur_vec_q;
          ffy_d   = dut_y;
        end
        if (cur_vec_q == LAST_VEC) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          cur_vec_d = cur_vec_q + 1'b1;
          state_d   = S_DRIVE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dut_in_q  <= '0;
      cur_vec_q <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      ffv_q     <= 1'b0;
      ffvec_q   <= '0;
      ffy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dut_in_q  <= dut_in_d;
      cur_vec_q <= cur_vec_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      ffv_q     <= ffv_d;
      ffvec_q   <= ffvec_d;
      ffy_q     <= ffy_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign cur_vec   = cur_vec_q;
  assign err_count = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_y     = ffy_q;
`else
  // Capture state exists but has no observers when the feature is off.
  logic unused_ff;
  assign unused_ff = ffv_q ^ ffy_q ^ (^ffvec_q);
`endif

endmodule
